// File: rtl/img_pkg.sv
// Shared pixel types and constants for the video pre-filter path.
package img_pkg;
    localparam int         PIX_W        = 24;
    localparam int         SUM_W        = 12;
    localparam logic [3:0] VIDEO_PKT_ID = 4'h0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Divide-by-9 approximation: (sum * mul) >> 9, product fits in 17 bits.
    function automatic logic [7:0] scale_mean(input logic [SUM_W-1:0] sum, input logic [16:0] mul);
        logic [16:0] w_prod;
        w_prod = 17'(sum) * mul;
        return w_prod[16:9];
    endfunction
endpackage

// File: rtl/line_buf.sv
// Single-port row store holding two packed row entries per column; an access returns
// the old pair and ages it (low half moves to high half, new entry enters low half).
module line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH/2-1:0]       i_din,
    output logic [WIDTH-1:0]         o_q
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            o_q            <= r_mem[i_addr];
            r_mem[i_addr]  <= {r_mem[i_addr][WIDTH/2-1:0], i_din};
        end
    end
endmodule

// File: rtl/stream_box_blur3x3.sv
// Avalon-ST 3x3 box blur: two-stage pipeline (window/line-buffer access, then sum/scale).
// Header words, control packets and bypass-mode beats pass through untouched.
module stream_box_blur3x3
    import img_pkg::*;
#(
    parameter int IMAGE_W   = 640,
    parameter int IMAGE_H   = 480,
    parameter int SCALE_MUL = 57
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] sink_data,
    input  logic             sink_valid,
    output logic             sink_ready,
    input  logic             sink_sop,
    input  logic             sink_eop,
    output logic [PIX_W-1:0] source_data,
    output logic             source_valid,
    input  logic             source_ready,
    output logic             source_sop,
    output logic             source_eop,
    input  logic             mode
);
    localparam int XW = $clog2(IMAGE_W);
    localparam int YW = $clog2(IMAGE_H);

    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic                 r_pkt_video;
    logic [1:0]           r_vld_pipe;
    pixel_t               r_s1_data;
    logic                 r_s1_sop, r_s1_eop, r_s1_vid, r_s1_edge;
    pixel_t [2:0]         r_c1, r_c2;
    pixel_t [2:0]         w_col;
    logic [2*PIX_W-1:0]   w_lb_q;
    logic                 w_adv, w_take, w_vid, w_s2_go;
    logic [SUM_W-1:0]     w_sum_r, w_sum_g, w_sum_b;
    pixel_t               w_filt;

    assign w_adv        = ~source_valid | source_ready;
    assign sink_ready   = w_adv;
    assign w_take       = w_adv & sink_valid;
    assign w_vid        = w_take & ~sink_sop & r_pkt_video & mode;
    assign w_s2_go      = w_adv & r_vld_pipe[0] & r_s1_vid;
    assign source_valid = r_vld_pipe[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_pkt_video <= 1'b0;
        end else if (w_take & sink_sop) begin
            r_pkt_video <= (sink_data[3:0] == VIDEO_PKT_ID);
            r_x         <= '0;
            r_y         <= '0;
        end else if (w_vid) begin
            if (r_x == XW'(IMAGE_W - 1)) begin
                r_x <= '0;
                if (r_y != YW'(IMAGE_H - 1)) r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    line_buf #(.DEPTH(IMAGE_W), .WIDTH(2*PIX_W)) u_lb (
        .clk    (clk),
        .i_en   (w_vid),
        .i_addr (r_x),
        .i_din  (sink_data),
        .o_q    (w_lb_q)
    );

    // Current column: rows y-2, y-1 from the line buffer, row y from the S1 register.
    assign w_col[0] = pixel_t'(w_lb_q[2*PIX_W-1:PIX_W]);
    assign w_col[1] = pixel_t'(w_lb_q[PIX_W-1:0]);
    assign w_col[2] = r_s1_data;

    always_ff @(posedge clk) begin
        if (w_s2_go) begin
            r_c2 <= r_c1;
            r_c1 <= w_col;
        end
    end

    always_comb begin
        w_sum_r = '0;
        w_sum_g = '0;
        w_sum_b = '0;
        for (int i = 0; i < 3; i++) begin
            w_sum_r = w_sum_r + SUM_W'(w_col[i].r) + SUM_W'(r_c1[i].r) + SUM_W'(r_c2[i].r);
            w_sum_g = w_sum_g + SUM_W'(w_col[i].g) + SUM_W'(r_c1[i].g) + SUM_W'(r_c2[i].g);
            w_sum_b = w_sum_b + SUM_W'(w_col[i].b) + SUM_W'(r_c1[i].b) + SUM_W'(r_c2[i].b);
        end
        w_filt.r = scale_mean(w_sum_r, 17'(SCALE_MUL));
        w_filt.g = scale_mean(w_sum_g, 17'(SCALE_MUL));
        w_filt.b = scale_mean(w_sum_b, 17'(SCALE_MUL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe  <= '0;
            r_s1_data   <= '0;
            r_s1_sop    <= 1'b0;
            r_s1_eop    <= 1'b0;
            r_s1_vid    <= 1'b0;
            r_s1_edge   <= 1'b0;
            source_data <= '0;
            source_sop  <= 1'b0;
            source_eop  <= 1'b0;
        end else if (w_adv) begin
            r_vld_pipe  <= {r_vld_pipe[0], sink_valid};
            r_s1_data   <= pixel_t'(sink_data);
            r_s1_sop    <= sink_sop;
            r_s1_eop    <= sink_eop;
            r_s1_vid    <= w_vid;
            r_s1_edge   <= (r_x < XW'(2)) | (r_y < YW'(2));
            source_data <= (r_s1_vid & ~r_s1_edge) ? w_filt : r_s1_data;
            source_sop  <= r_s1_sop;
            source_eop  <= r_s1_eop;
        end
    end
endmodule

// File: tb/tb_stream_box_blur3x3.sv
// Directed bench for stream_box_blur3x3 on a reduced 16x14 image.
module tb_stream_box_blur3x3;
    localparam int W = 16;
    localparam int H = 14;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] sink_data = '0;
    logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready = 1'b1;
    logic        mode = 1'b1;

    int          total = 0;
    int          bad = 0;
    bit          stall_en = 0, gap_en = 0;
    logic [25:0] out_q[$];
    logic [25:0] exp_q[$];
    logic [25:0] ref_q[$];
    logic [23:0] px_q[$];

    stream_box_blur3x3 #(.IMAGE_W(W), .IMAGE_H(H), .SCALE_MUL(57)) dut (
        .clk(clk), .reset(reset),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic v, input logic [23:0] d, input logic s, input logic e,
                         output logic acc);
        @(negedge clk);
        sink_valid   = v;
        sink_data    = d;
        sink_sop     = s;
        sink_eop     = e;
        source_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (source_valid && source_ready) out_q.push_back({source_sop, source_eop, source_data});
        acc = v && sink_ready;
    endtask

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        logic acc;
        int   n = 0;
        if (gap_en && $urandom_range(0, 2) == 0) drive(1'b0, '0, 1'b0, 1'b0, acc);
        acc = 1'b0;
        while (!acc && n < 64) begin
            drive(1'b1, d, s, e, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    function automatic logic [23:0] pat(input int i, input int seed);
        return {8'(i * 7 + seed), 8'(i * 13 + seed * 3), 8'(i * 29 + 91)};
    endfunction

    function automatic logic [23:0] blur(input int i);
        int c, r, sr, sg, sb;
        logic [23:0] p;
        c = i % W;
        r = i / W;
        if (c < 2 || r < 2) return px_q[i];
        sr = 0; sg = 0; sb = 0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                p = px_q[(r - dy) * W + c - dx];
                sr += int'(p[23:16]);
                sg += int'(p[15:8]);
                sb += int'(p[7:0]);
            end
        return {8'((sr * 57) >> 9), 8'((sg * 57) >> 9), 8'((sb * 57) >> 9)};
    endfunction

    task automatic send_frame(input logic [23:0] hdr, input bit filt, input int n);
        exp_q.push_back({1'b1, n == 0, hdr});
        send(hdr, 1'b1, n == 0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, i == n - 1, filt ? blur(i) : px_q[i]});
            send(px_q[i], 1'b0, i == n - 1);
        end
    endtask

    task automatic check_frame(input string tag);
        int nm = 0;
        int k = 0;
        while (out_q.size() < exp_q.size() && k < 3000) begin
            idle(1);
            k++;
        end
        idle(4);
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) nm++;
        chk({tag, "_mismatches"}, nm, 0);
    endtask

    function automatic logic [23:0] opx(input int x, input int y);
        logic [25:0] b;
        b = out_q[1 + y * W + x];
        return b[23:0];
    endfunction

    task automatic clear_q();
        out_q.delete();
        exp_q.delete();
        px_q.delete();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 32'(source_valid), 32'd0);
        chk({tag, "_data"},  32'(source_data),  32'd0);
        chk({tag, "_sop"},   32'(source_sop),   32'd0);
        chk({tag, "_eop"},   32'(source_eop),   32'd0);
        chk({tag, "_ready"}, 32'(sink_ready),   32'd1);
    endtask

    initial begin
        logic acc;
        int   n1c;

        // Reset state
        idle(2);
        reset_checks("rst");
        reset = 1'b0;

        // Single-beat control packet: two-cycle latency, bit-exact
        drive(1'b1, 24'h00000F, 1'b1, 1'b1, acc);
        idle(1);
        chk("lat_not_early", 32'(source_valid), 32'd0);
        idle(1);
        chk("lat_valid", 32'(source_valid), 32'd1);
        chk("lat_beat", 32'({source_sop, source_eop, source_data}), 32'({2'b11, 24'h00000F}));
        idle(2);
        clear_q();

        // 1: constant 0x646464
        for (int i = 0; i < NPIX; i++) px_q.push_back(24'h646464);
        send_frame(24'h0, 1'b1, NPIX);
        check_frame("t1");
        chk("t1_mid", 32'(opx(5, 5)), 32'h646464);
        clear_q();

        // 2: all white, no overflow
        for (int i = 0; i < NPIX; i++) px_q.push_back(24'hFFFFFF);
        send_frame(24'h0, 1'b1, NPIX);
        check_frame("t2");
        chk("t2_mid", 32'(opx(7, 7)), 32'hFFFFFF);
        clear_q();

        // 3: single red dot at (10,10)
        for (int i = 0; i < NPIX; i++) px_q.push_back(i == 10 * W + 10 ? 24'hFF0000 : 24'h0);
        send_frame(24'h0, 1'b1, NPIX);
        check_frame("t3");
        chk("t3_10_10", 32'(opx(10, 10)), 32'h1C0000);
        chk("t3_12_11", 32'(opx(12, 11)), 32'h1C0000);
        chk("t3_10_12", 32'(opx(10, 12)), 32'h1C0000);
        chk("t3_9_11",  32'(opx(9, 11)),  32'h0);
        chk("t3_11_13", 32'(opx(11, 13)), 32'h0);
        chk("t3_13_11", 32'(opx(13, 11)), 32'h0);
        n1c = 0;
        for (int i = 1; i < out_q.size(); i++) if (out_q[i][23:0] == 24'h1C0000) n1c++;
        chk("t3_dot_count", n1c, 9);
        clear_q();

        // 4: control packet then video frame
        px_q.push_back(24'hAA55AA);
        px_q.push_back(24'h123456);
        send_frame(24'h00000F, 1'b0, 2);
        check_frame("t4_ctl");
        clear_q();
        for (int i = 0; i < NPIX; i++) px_q.push_back(pat(i, 3));
        send_frame(24'h0, 1'b1, NPIX);
        check_frame("t4_vid");
        ref_q = out_q;
        out_q.delete();
        exp_q.delete();

        // 5: same frame under random backpressure and input gaps
        stall_en = 1;
        gap_en   = 1;
        send_frame(24'h0, 1'b1, NPIX);
        check_frame("t5");
        n1c = 0;
        for (int i = 0; i < ref_q.size(); i++) if (i >= out_q.size() || out_q[i] !== ref_q[i]) n1c++;
        chk("t5_vs_nostall", n1c, 0);
        chk("t5_count_vs_nostall", out_q.size(), ref_q.size());
        stall_en = 0;
        gap_en   = 0;
        clear_q();

        // Oversized frame: y saturates and filtering continues
        for (int i = 0; i < NPIX + 2 * W; i++) px_q.push_back(pat(i, 17));
        send_frame(24'h0, 1'b1, NPIX + 2 * W);
        check_frame("tsat");
        clear_q();

        // Short frame; the next SOP must restart the counters
        for (int i = 0; i < 3 * W + 5; i++) px_q.push_back(pat(i, 41));
        send_frame(24'h0, 1'b1, 3 * W + 5);
        check_frame("tshort");
        clear_q();

        // Bypass mode
        mode = 1'b0;
        for (int i = 0; i < NPIX; i++) px_q.push_back(pat(i, 77));
        send_frame(24'h0, 1'b0, NPIX);
        check_frame("tbyp");
        mode = 1'b1;
        clear_q();

        // 6: reset mid-frame, orphan beats, then a clean frame
        send(24'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8 * W + 9; i++) send(pat(i, 5), 1'b0, 1'b0);
        reset = 1'b1;
        idle(2);
        reset_checks("rst2");
        reset = 1'b0;
        clear_q();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b0, i == 4, pat(i, 9)});
            send(pat(i, 9), 1'b0, i == 4);
        end
        check_frame("t6_orphan");
        clear_q();
        for (int i = 0; i < NPIX; i++) px_q.push_back(pat(i, 23));
        send_frame(24'h0, 1'b1, NPIX);
        check_frame("t6_frame");
        clear_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
